// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: valid/ready input queue, combinational decode of the
// queue head, load-use stall, jump/external flush, and a registered ID/EX output slot.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_alu_op,
   output logic [7:0]      out_ctrl,
   output logic            out_illegal,
   output logic            jump_flush
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASSB = 4'd10;

   logic [31:0]      instr_q [DEPTH];
   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;

   logic [31:0]      head;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [4:0]       rs1_d;
   logic [31:0]      imm32;
   logic [XLEN-1:0]  imm_x;
   logic [3:0]       alu_d;
   logic [7:0]       ctrl_d;
   logic             illegal_d, uses_rs1, uses_rs2, is_jump;
   logic             hazard, issue, push;

   function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_sel = ALU_SLL;
         3'b010:  alu_sel = ALU_SLT;
         3'b011:  alu_sel = ALU_SLTU;
         3'b100:  alu_sel = ALU_XOR;
         3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_sel = ALU_OR;
         default: alu_sel = ALU_AND;
      endcase
   endfunction

   assign in_ready = rst_n && (count < CNT_W'(DEPTH)) && !flush && !jump_flush;
   assign push     = in_valid && in_ready;

   always_comb begin
      head      = instr_q[rd_ptr];
      opcode    = head[6:0];
      funct3    = head[14:12];
      funct7    = head[31:25];
      rs1_d     = head[19:15];
      imm32     = '0;
      alu_d     = ALU_ADD;
      ctrl_d    = 8'h00;
      illegal_d = 1'b0;
      uses_rs1  = 1'b1;
      uses_rs2  = 1'b0;
      is_jump   = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl_d   = 8'h80;
            uses_rs2 = 1'b1;
            alu_d    = alu_sel(funct3, funct7[5]);
            if (!(funct7 == 7'b0000000 ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
               illegal_d = 1'b1;
         end
         OP_I: begin
            ctrl_d = 8'hC0;
            imm32  = {{20{head[31]}}, head[31:20]};
            alu_d  = alu_sel(funct3, (funct3 == 3'b101) && funct7[5]);
            // shift-immediates carry funct7 in the upper immediate bits
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               imm32 = {27'b0, head[24:20]};
               if (!(funct7 == 7'b0000000 || (funct3 == 3'b101 && funct7 == 7'b0100000)))
                  illegal_d = 1'b1;
            end
         end
         OP_LOAD: begin
            ctrl_d = 8'hF0;
            imm32  = {{20{head[31]}}, head[31:20]};
         end
         OP_STORE: begin
            ctrl_d   = 8'h48;
            uses_rs2 = 1'b1;
            imm32    = {{20{head[31]}}, head[31:25], head[11:7]};
         end
         OP_BRANCH: begin
            ctrl_d   = 8'h04;
            uses_rs2 = 1'b1;
            alu_d    = ALU_SUB;
            imm32    = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
         end
         OP_JAL: begin
            ctrl_d   = 8'h82;
            uses_rs1 = 1'b0;
            is_jump  = 1'b1;
            imm32    = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
         end
         OP_JALR: begin
            ctrl_d  = 8'hC3;
            is_jump = 1'b1;
            imm32   = {{20{head[31]}}, head[31:20]};
         end
         OP_LUI: begin
            ctrl_d   = 8'hC0;
            alu_d    = ALU_PASSB;
            uses_rs1 = 1'b0;
            rs1_d    = 5'd0;
            imm32    = {head[31:12], 12'b0};
         end
         default: illegal_d = 1'b1;
      endcase
      if (illegal_d) begin
         ctrl_d  = 8'h00;
         alu_d   = ALU_ADD;
         is_jump = 1'b0;
      end
      imm_x        = {XLEN{imm32[31]}};
      imm_x[31:0]  = imm32;
   end

   assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                   ((uses_rs1 && ex_rd == head[19:15]) || (uses_rs2 && ex_rd == head[24:20]));
   assign issue  = (count != '0) && (!out_valid || out_ready) && !hazard && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr] <= in_instr;
         pc_q[wr_ptr]    <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         out_valid   <= 1'b0;
         jump_flush  <= 1'b0;
         out_pc      <= '0;
         out_rs1     <= '0;
         out_rs2     <= '0;
         out_rd      <= '0;
         out_funct3  <= '0;
         out_imm     <= '0;
         out_alu_op  <= '0;
         out_ctrl    <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         out_valid  <= 1'b0;
         jump_flush <= 1'b0;
      end else begin
         jump_flush <= issue && is_jump;
         // a taken jump kills everything younger, including a same-cycle push
         if (issue && is_jump) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(issue);
         end
         if (issue) begin
            out_valid   <= 1'b1;
            out_pc      <= pc_q[rd_ptr];
            out_rs1     <= rs1_d;
            out_rs2     <= head[24:20];
            out_rd      <= head[11:7];
            out_funct3  <= funct3;
            out_imm     <= imm_x;
            out_alu_op  <= alu_d;
            out_ctrl    <= ctrl_d;
            out_illegal <= illegal_d;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-computed decode results, stalls, jumps, flush.
module tb_decode_stage;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, flush, ex_mem_read, out_valid, out_ready;
   logic        out_illegal, jump_flush;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [4:0]  ex_rd, out_rs1, out_rs2, out_rd;
   logic [2:0]  out_funct3;
   logic [3:0]  out_alu_op;
   logic [7:0]  out_ctrl;
   int          checks = 0;
   int          errors = 0;

   decode_stage #(.XLEN(32), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
      .out_imm(out_imm), .out_alu_op(out_alu_op), .out_ctrl(out_ctrl),
      .out_illegal(out_illegal), .jump_flush(jump_flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      ex_mem_read = 1'b0; ex_rd = '0; out_ready = 1'b1;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (jump_flush !== 1'b0) begin errors++; $display("FAIL rst_jump_flush got %b exp 0", jump_flush); end
      checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_ctrl !== 8'h0) begin errors++; $display("FAIL rst_fields got pc=%h imm=%h ctrl=%h exp 0", out_pc, out_imm, out_ctrl); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      rst_n = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_not_yet got %b exp 0", out_valid); end
      in_instr = 32'h123452B7; in_pc = 32'h104;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL addi_issue got v=%b pc=%h exp 1 100", out_valid, out_pc); end
      checks++; if (out_rd !== 5'd1 || out_imm !== 32'h5 || out_alu_op !== 4'd0) begin errors++; $display("FAIL addi_dec got rd=%0d imm=%h alu=%0d exp 1 5 0", out_rd, out_imm, out_alu_op); end
      checks++; if (out_ctrl !== 8'hC0 || out_illegal !== 1'b0) begin errors++; $display("FAIL addi_ctrl got %h ill=%b exp c0 0", out_ctrl, out_illegal); end
      in_instr = 32'h4031D193; in_pc = 32'h108;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin errors++; $display("FAIL lui_issue got v=%b pc=%h exp 1 104", out_valid, out_pc); end
      checks++; if (out_rs1 !== 5'd0 || out_rd !== 5'd5 || out_imm !== 32'h12345000) begin errors++; $display("FAIL lui_dec got rs1=%0d rd=%0d imm=%h exp 0 5 12345000", out_rs1, out_rd, out_imm); end
      checks++; if (out_alu_op !== 4'd10 || out_ctrl !== 8'hC0) begin errors++; $display("FAIL lui_alu got alu=%0d ctrl=%h exp 10 c0", out_alu_op, out_ctrl); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h108) begin errors++; $display("FAIL srai_issue got v=%b pc=%h exp 1 108", out_valid, out_pc); end
      checks++; if (out_imm !== 32'h3 || out_alu_op !== 4'd7 || out_illegal !== 1'b0) begin errors++; $display("FAIL srai_dec got imm=%h alu=%0d ill=%b exp 3 7 0", out_imm, out_alu_op, out_illegal); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_rtype_store_branch();
      in_valid = 1'b1; in_instr = 32'h401101B3; in_pc = 32'h200;
      tick();
      in_instr = 32'h001101B3; in_pc = 32'h204;
      tick();
      checks++; if (out_alu_op !== 4'd1 || out_rs1 !== 5'd2 || out_rs2 !== 5'd1 || out_rd !== 5'd3) begin errors++; $display("FAIL sub_dec got alu=%0d rs1=%0d rs2=%0d rd=%0d exp 1 2 1 3", out_alu_op, out_rs1, out_rs2, out_rd); end
      checks++; if (out_ctrl !== 8'h80 || out_imm !== 32'h0) begin errors++; $display("FAIL sub_ctrl got ctrl=%h imm=%h exp 80 0", out_ctrl, out_imm); end
      in_instr = 32'h0020A423; in_pc = 32'h208;
      tick();
      checks++; if (out_valid !== 1'b1 || out_alu_op !== 4'd0 || out_pc !== 32'h204) begin errors++; $display("FAIL add_dec got v=%b alu=%0d pc=%h exp 1 0 204", out_valid, out_alu_op, out_pc); end
      in_instr = 32'hFE000EE3; in_pc = 32'h20C;
      tick();
      checks++; if (out_ctrl !== 8'h48 || out_imm !== 32'h8 || out_rs2 !== 5'd2 || out_alu_op !== 4'd0) begin errors++; $display("FAIL sw_dec got ctrl=%h imm=%h rs2=%0d alu=%0d exp 48 8 2 0", out_ctrl, out_imm, out_rs2, out_alu_op); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_imm !== 32'hFFFFFFFC || out_ctrl !== 8'h04 || out_alu_op !== 4'd1) begin errors++; $display("FAIL beq_dec got imm=%h ctrl=%h alu=%0d exp fffffffc 04 1", out_imm, out_ctrl, out_alu_op); end
      tick();
   endtask

   task automatic test_load_use();
      in_valid = 1'b1; in_instr = 32'h001101B3; in_pc = 32'h400;
      tick();
      in_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd2;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_rs1_stall got %b exp 0", out_valid); end
      ex_mem_read = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin errors++; $display("FAIL hz_rs1_release got v=%b pc=%h exp 1 400", out_valid, out_pc); end
      tick();
      in_valid = 1'b1; in_pc = 32'h404;
      tick();
      in_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_rs2_stall got %b exp 0", out_valid); end
      ex_mem_read = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h404) begin errors++; $display("FAIL hz_rs2_release got v=%b pc=%h exp 1 404", out_valid, out_pc); end
      tick();
      in_valid = 1'b1; in_pc = 32'h408;
      tick();
      in_valid = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd0;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h408) begin errors++; $display("FAIL hz_x0_nostall got v=%b pc=%h exp 1 408", out_valid, out_pc); end
      ex_mem_read = 1'b0;
      tick();
   endtask

   task automatic test_jump();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h600;
      tick();
      in_instr = 32'h008000EF; in_pc = 32'h604;
      tick();
      in_instr = 32'h00500093; in_pc = 32'h608;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h600 || in_ready !== 1'b0) begin errors++; $display("FAIL jmp_setup got v=%b pc=%h rdy=%b exp 1 600 0", out_valid, out_pc, in_ready); end
      in_instr = 32'h123452B7; in_pc = 32'h60C; out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h604 || out_imm !== 32'h8) begin errors++; $display("FAIL jal_issue got v=%b pc=%h imm=%h exp 1 604 8", out_valid, out_pc, out_imm); end
      checks++; if (out_ctrl !== 8'h82 || out_rd !== 5'd1) begin errors++; $display("FAIL jal_ctrl got ctrl=%h rd=%0d exp 82 1", out_ctrl, out_rd); end
      checks++; if (jump_flush !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL jal_pulse got jf=%b rdy=%b exp 1 0", jump_flush, in_ready); end
      in_valid = 1'b0;
      tick();
      checks++; if (jump_flush !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL jal_after got jf=%b v=%b exp 0 0", jump_flush, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL jal_younger got v=%b pc=%h exp 0", out_valid, out_pc); end
   endtask

   task automatic test_backpressure_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300;
      tick();
      in_pc = 32'h304;
      tick();
      in_pc = 32'h308;
      tick();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300) begin errors++; $display("FAIL bp_full got rdy=%b v=%b pc=%h exp 0 1 300", in_ready, out_valid, out_pc); end
      in_pc = 32'h30C;
      tick();
      checks++; if (out_pc !== 32'h300 || out_rd !== 5'd1 || out_imm !== 32'h5 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got pc=%h rd=%0d imm=%h v=%b exp 300 1 5 1", out_pc, out_rd, out_imm, out_valid); end
      flush = 1'b1; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b exp 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_after got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got v=%b pc=%h exp 0", out_valid, out_pc); end
      in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h500;
      tick();
      in_instr = 32'h401141B3; in_pc = 32'h504;
      tick();
      checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_ctrl !== 8'h00 || out_alu_op !== 4'd0) begin errors++; $display("FAIL ill_opcode got v=%b ill=%b ctrl=%h alu=%0d exp 1 1 00 0", out_valid, out_illegal, out_ctrl, out_alu_op); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_pc !== 32'h504 || out_illegal !== 1'b1 || out_ctrl !== 8'h00 || out_alu_op !== 4'd0) begin errors++; $display("FAIL ill_funct7 got pc=%h ill=%b ctrl=%h alu=%0d exp 504 1 00 0", out_pc, out_illegal, out_ctrl, out_alu_op); end
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_rtype_store_branch();
      test_load_use();
      test_jump();
      test_backpressure_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised instruction-decode stage for the RV32I core, sitting between fetch and execute. Instructions enter through a valid/ready input queue. Each is decoded into register indices, a sign-correct immediate, an ALU op and an 8-bit control word, then held in a registered ID/EX output slot. The stage adds load-use hazard stalling, external and jump flushing, illegal-instruction flagging, and full RV32I ALU op coverage.

## Interface
Parameters:
- XLEN, 32, datapath/PC/immediate width (≥32; immediates sign-extended to XLEN).
- DEPTH, 2, input queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept: count<DEPTH && !flush && !jump_flush.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  external redirect; discards queue and output slot.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination of the instruction in EX.
- out_valid  out  1  output slot holds a decoded instruction.
- out_ready  in  1  execute accepts the slot.
- out_pc  out  XLEN  PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_funct3  out  3  funct3 field.
- out_imm  out  XLEN  immediate.
- out_alu_op  out  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10.
- out_ctrl  out  8  {reg_we, alu_src, writeback, mem_read, mem_we, branch, jump, jalr}.
- out_illegal  out  1  unsupported encoding.
- jump_flush  out  1  one-cycle pulse when a JAL/JALR is issued.

## Operation
- Queue: circular buffer with rd/wr pointers and count.
  - Write on in_valid&&in_ready.
  - Read (issue) as defined below.
  - No same-cycle bypass: a full queue stays not-ready even while it pops.
- Decode is combinational on the queue head.
  - R-type: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND via funct3/funct7.
  - I-type ALU: immediate forms of the same ops. SLLI/SRLI/SRAI imm = zero-extended shamt[24:20].
  - LUI: alu PASSB, rs1 forced 0, imm={instr[31:12],12'b0}.
  - LW: ADD. SW: ADD, S-imm.
  - BEQ..BGEU: SUB, B-imm = sext({i[31],i[7],i[30:25],i[11:8],0}).
  - JAL: J-imm. JALR: I-imm.
- out_ctrl per opcode: R 10000000, I 11000000, LW 11110000, SW 01001000, B 00000100, JAL 10000010, JALR 11000011, LUI 11000000.
- Illegal: unknown opcode, or an invalid funct7 for its funct3. Result: out_ctrl=0, out_illegal=1, alu_op=ADD. An illegal instruction is still issued.
- Hazard when ex_mem_read && ex_rd!=0 && ((head uses rs1 && ex_rd==rs1) || (head uses rs2 && ex_rd==rs2)).
  - rs1 is used by all opcodes except LUI and JAL.
  - rs2 is used by R, S and B.
- issue = queue non-empty && (!out_valid || out_ready) && !hazard && !flush.
  - On issue: pop head; load the output slot; out_valid=1.
  - If out_valid && out_ready && !issue: out_valid←0.
  - If out_valid && !out_ready: the slot holds all fields stable.
- Jump: issuing JAL/JALR sets jump_flush=1 for the next cycle and clears all remaining queue entries at the same edge. in_ready=0 while jump_flush=1.
- flush (priority over everything): at the edge, queue count←0, pointers←0, out_valid←0, jump_flush←0. in_valid that cycle is ignored.

## Timing
- Reset (rst_n=0 at edge): out_valid=0, jump_flush=0, count=0, pointers=0; all out_* data fields 0; in_ready=0 during reset cycle, 1 after.
- Latency: instruction accepted at edge k → out_valid with its fields after edge k+1, provided no stall.
- Throughput 1/cycle with out_ready held high and no hazards.
- Hazard stall lasts while its inputs hold. A hazard suppresses issue only; the output slot still drains on out_ready.
- Simultaneous write+read on a non-full queue: count unchanged, both pointers advance, wrap modulo DEPTH.
- Reset or flush mid-stream: nothing in flight survives. First valid output after flush needs a fresh accept (≥2 edges).

## Test plan
- Reset then stream, out_ready=1:
  - 0x00500093 (addi x1,x0,5) → rd=1, imm=5, alu=0, ctrl=11000000.
  - 0x123452B7 (lui) → rs1=0, imm=0x12345000, alu=10.
  - All outputs come 1 edge after acceptance, back-to-back.
- Stream 0x401101B3 then 0x001101B3 → alu_op=1 (SUB) then 0 (ADD).
- 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, ctrl=00000100.
- Load-use: head 0x001101B3 with ex_mem_read=1, ex_rd=2 held 1 cycle → no issue that cycle, issue next. Repeat with ex_rd=0 → no stall.
- Jump: queue holds 0x008000EF (jal x1,8) then two more instructions → JAL issued with imm=8, jump_flush pulses 1 cycle, younger entries never appear, in_ready=0 during the pulse.
- Back-pressure and flush:
  - Hold out_ready=0: slot stable, queue fills to DEPTH, in_ready=0.
  - Assert flush → next cycle out_valid=0, count=0, in_ready=1.
  - Opcode 0x7F → out_illegal=1, ctrl=0.
